// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU pipeline control blocks.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MUL_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import cpu_ctrl_pkg::*;
(
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       hit
);

  // r0 is hardwired to zero, so a load into it never creates a dependency
  assign hit = idex_mem_read && (idex_rt != REG_ZERO) &&
               ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: start gating, load-use,
// branch flush, multi-cycle EX freeze, data-memory stall and a stall counter.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic             IDEX_MemRead_i,
  input  logic             branch_taken_i,
  input  logic             mul_start_i,
  input  logic             dmem_stall_i,
  output logic             PCWrite_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_write_o,
  output logic             IDEX_bubble_o,
  output logic             EXMEM_write_o,
  output logic             EXMEM_bubble_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 2);

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [CNT_W-1:0] stall_cnt;
  logic             load_use;

  load_use_detect u_load_use (
    .idex_mem_read (IDEX_MemRead_i),
    .idex_rt       (IDEX_rt_i),
    .ifid_rs       (IFID_rs_i),
    .ifid_rt       (IFID_rt_i),
    .hit           (load_use)
  );

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    PCWrite_o      = 1'b1;
    IFID_write_o   = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_write_o   = 1'b1;
    IDEX_bubble_o  = 1'b0;
    EXMEM_write_o  = 1'b1;
    EXMEM_bubble_o = 1'b0;
    case (state)
      ST_RUN: begin
        if (dmem_stall_i) begin
          {PCWrite_o, IFID_write_o, IDEX_write_o, EXMEM_write_o} = 4'b0000;
        end else if (mul_start_i) begin
          {PCWrite_o, IFID_write_o, IDEX_write_o} = 3'b000;
          EXMEM_bubble_o = 1'b1;
          cnt_nx         = MUL_LOAD;
          state_nx       = ST_MUL_WAIT;
        end else if (load_use) begin
          // branch flush is dropped: the branch re-resolves once the load lands
          PCWrite_o     = 1'b0;
          IFID_write_o  = 1'b0;
          IDEX_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          IFID_flush_o = 1'b1;
        end
      end
      ST_MUL_WAIT: begin
        if (dmem_stall_i) begin
          {PCWrite_o, IFID_write_o, IDEX_write_o, EXMEM_write_o} = 4'b0000;
        end else begin
          {PCWrite_o, IFID_write_o, IDEX_write_o} = 3'b000;
          EXMEM_bubble_o = 1'b1;
          if (cnt == 4'd0) state_nx = ST_RUN;
          else             cnt_nx   = cnt - 4'd1;
        end
      end
      default: begin
        {PCWrite_o, IFID_write_o, IDEX_write_o, EXMEM_write_o} = 4'b0000;
        IDEX_bubble_o  = 1'b1;
        EXMEM_bubble_o = 1'b1;
        state_nx       = (state == ST_IDLE && start_i) ? ST_RUN : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state != ST_IDLE && !PCWrite_o && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state_o        = state;
  assign stall_cycles_o = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: directed and random stimulus against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 6;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [4:0]       IFID_rs_i = '0, IFID_rt_i = '0, IDEX_rt_i = '0;
  logic             IDEX_MemRead_i = 1'b0, branch_taken_i = 1'b0;
  logic             mul_start_i = 1'b0, dmem_stall_i = 1'b0;
  logic             PCWrite_o, IFID_write_o, IFID_flush_o, IDEX_write_o;
  logic             IDEX_bubble_o, EXMEM_write_o, EXMEM_bubble_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cycles_o;

  pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .IFID_rs_i      (IFID_rs_i),
    .IFID_rt_i      (IFID_rt_i),
    .IDEX_rt_i      (IDEX_rt_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .branch_taken_i (branch_taken_i),
    .mul_start_i    (mul_start_i),
    .dmem_stall_i   (dmem_stall_i),
    .PCWrite_o      (PCWrite_o),
    .IFID_write_o   (IFID_write_o),
    .IFID_flush_o   (IFID_flush_o),
    .IDEX_write_o   (IDEX_write_o),
    .IDEX_bubble_o  (IDEX_bubble_o),
    .EXMEM_write_o  (EXMEM_write_o),
    .EXMEM_bubble_o (EXMEM_bubble_o),
    .state_o        (state_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // ctl bit order: PCWrite, IFID_write, IFID_flush, IDEX_write, IDEX_bubble, EXMEM_write, EXMEM_bubble
  typedef struct packed {
    logic [6:0]       ctl;
    logic [1:0]       st;
    logic [CNT_W-1:0] stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // reference model: core started?, freeze cycles still owed to a multi-cycle op, stall count
  bit m_started = 1'b0;
  int m_mul_left = 0;
  int m_stall = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endfunction

  task automatic cyc(input logic st, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] ert, input logic mr, input logic br,
                     input logic mul, input logic dm);
    exp_t e;
    logic lu;
    @(posedge clk_i); #1;
    start_i = st; IFID_rs_i = rs; IFID_rt_i = rt; IDEX_rt_i = ert;
    IDEX_MemRead_i = mr; branch_taken_i = br; mul_start_i = mul; dmem_stall_i = dm;
    e.stall = CNT_W'(m_stall);
    lu = mr && (ert != 5'd0) && (ert == rs || ert == rt);
    if (!m_started) begin
      e.ctl = 7'b0000101;
      e.st  = 2'd0;
      if (st) m_started = 1'b1;
    end else if (m_mul_left > 0) begin
      e.st = 2'd2;
      if (dm) e.ctl = 7'b0000000;
      else begin
        e.ctl = 7'b0000011;
        m_mul_left--;
      end
    end else begin
      e.st = 2'd1;
      if (dm)       e.ctl = 7'b0000000;
      else if (mul) begin
        e.ctl = 7'b0000011;
        m_mul_left = MUL_LAT - 1;
      end
      else if (lu)  e.ctl = 7'b0001110;
      else          e.ctl = {2'b11, br, 4'b1010};
    end
    if (e.st != 2'd0 && !e.ctl[6] && m_stall < (1 << CNT_W) - 1) m_stall++;
    sb_q.push_back(e);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // asserts reset between edges and confirms it takes effect without a clock
  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    check("rst_state", state_o, 0);
    check("rst_stall", stall_cycles_o, 0);
    m_started = 1'b0; m_mul_left = 0; m_stall = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    start_i = 1'b0; IDEX_MemRead_i = 1'b0; branch_taken_i = 1'b0;
    mul_start_i = 1'b0; dmem_stall_i = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ctl", {PCWrite_o, IFID_write_o, IFID_flush_o, IDEX_write_o,
                      IDEX_bubble_o, EXMEM_write_o, EXMEM_bubble_o}, e.ctl);
        check("state", state_o, e.st);
        check("stall_cycles", stall_cycles_o, e.stall);
      end
    end
  end

  initial begin : stim
    do_reset();
    idle_cyc();
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cyc();
    cyc(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);

    do_reset();
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) idle_cyc();
    @(negedge clk_i);
    check("mul_freeze_len", stall_cycles_o, MUL_LAT);

    do_reset();
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cyc();
    repeat (3) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) idle_cyc();
    @(negedge clk_i);
    check("mul_dmem_freeze_len", stall_cycles_o, MUL_LAT + 3);

    do_reset();
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cyc();
    @(negedge clk_i);
    check("pre_reset_mul_wait", state_o, 2);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      cyc($urandom_range(0, 2) == 0,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
    end

    idle_cyc();
    @(negedge clk_i);
    @(negedge clk_i);
    check("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
